// File: rtl/logic_unit_acc.sv
// Registered two-operand bitwise logic unit with valid/ready handshakes.
// Each beat is either computed on its own, or folded into a multi-beat frame result.
module logic_unit_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [2:0]       op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_sat_q, out_sat_d;

  logic             beat;
  logic             accept;
  logic [WIDTH-1:0] fold_val;
  logic [CNT_W-1:0] cnt_inc;
  logic             sat_inc;

  function automatic logic [WIDTH-1:0] logic_f(input logic [2:0] f,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    case (f)
      3'd0:    logic_f = x & y;
      3'd1:    logic_f = x | y;
      3'd2:    logic_f = x ^ y;
      3'd3:    logic_f = ~(x & y);
      3'd4:    logic_f = ~(x | y);
      3'd5:    logic_f = ~(x ^ y);
      3'd6:    logic_f = ~x;
      default: logic_f = x;
    endcase
  endfunction

  assign in_ready = (state_q != HOLD) || out_ready;
  assign beat     = in_valid && in_ready;
  assign accept   = out_valid_q && out_ready;

  // NOT/PASS act on the incoming beat when folding, so the last beat wins.
  assign fold_val = logic_f(op_q, (op_q[2:1] == 2'b11) ? a : acc_q, a);
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign sat_inc  = sat_q || (cnt_q == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;

    if (accept) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end

    if (beat) begin
      if (state_q == ACC) begin
        acc_d = fold_val;
        cnt_d = cnt_inc;
        sat_d = sat_inc;
        if (in_last) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          out_data_d  = fold_val;
          out_count_d = cnt_inc;
          out_sat_d   = sat_inc;
        end
      end else if (!mode) begin
        state_d     = HOLD;
        out_valid_d = 1'b1;
        out_data_d  = logic_f(op, a, b);
        out_count_d = CNT_ONE;
        out_sat_d   = 1'b0;
      end else begin
        acc_d = a;
        cnt_d = CNT_ONE;
        sat_d = 1'b0;
        op_d  = op;
        if (in_last) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          out_data_d  = a;
          out_count_d = CNT_ONE;
          out_sat_d   = 1'b0;
        end else begin
          state_d = ACC;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_logic_unit_acc.sv
// Scoreboard bench for logic_unit_acc (WIDTH=8, CNT_W=2 so saturation is reachable).
module tb_logic_unit_acc;
  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       op = '0;
  logic             mode = 1'b0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  logic_unit_acc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .mode(mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cnt;
    logic       sat;
  } res_t;

  res_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rnd_bp  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: per-bit truth table indexed by {x_bit, y_bit}.
  function automatic logic [7:0] ref_f(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
    logic [3:0] tt;
    logic [7:0] r;
    case (f)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0111;
      3'd4: tt = 4'b0001;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  bit         m_busy = 1'b0;
  logic [2:0] m_op;
  logic [7:0] m_acc;
  int         m_cnt;
  bit         m_sat;

  task automatic push(input logic [7:0] d, input int c, input logic s);
    res_t r;
    r.data = d; r.cnt = c; r.sat = s;
    sb.push_back(r);
  endtask

  task automatic model_beat(input logic [7:0] ai, input logic [7:0] bi, input logic [2:0] opi,
                            input logic modei, input logic lasti);
    if (!m_busy) begin
      if (!modei) push(ref_f(opi, ai, bi), 1, 1'b0);
      else begin
        m_op = opi; m_acc = ai; m_cnt = 1; m_sat = 1'b0;
        if (lasti) push(ai, 1, 1'b0);
        else m_busy = 1'b1;
      end
    end else begin
      if (m_op == 3'd6) m_acc = ~ai;
      else if (m_op == 3'd7) m_acc = ai;
      else m_acc = ref_f(m_op, m_acc, ai);
      if (m_cnt == (1 << CNT_W) - 1) m_sat = 1'b1;
      else m_cnt++;
      if (lasti) begin
        push(m_acc, m_cnt, m_sat);
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] ai, input logic [7:0] bi, input logic [2:0] opi,
                      input logic modei, input logic lasti);
    int   w;
    logic rdy;
    w = 0;
    @(negedge clk);
    a = ai; b = bi; op = opi; mode = modei; in_last = lasti; in_valid = 1'b1;
    if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
    forever begin
      #1 rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      w++;
      if (w > 50) begin
        chk("send_timeout", 32'(w), 32'd0);
        break;
      end
      @(negedge clk);
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
    end
    if (rdy) model_beat(ai, bi, opi, modei, lasti);
    #1 in_valid = 1'b0;
  endtask

  // Compare each accepted result against the head of the scoreboard.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
        else begin
          e = sb.pop_front();
          $display("[TB] result data=0x%02h count=%0d sat=%0b (exp 0x%02h/%0d/%0b)",
                   out_data, out_count, out_sat, e.data, e.cnt, e.sat);
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_count", 32'(out_count), 32'(e.cnt));
          chk("out_sat", 32'(out_sat), 32'(e.sat));
        end
      end
    end
  end

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Elementwise sweep of all eight functions, one beat per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'hF0, 8'h3C, 3'(i), 1'b0, 1'b1);
    end
    drain();

    // Backpressure: result held stable, then a new beat taken on the accept cycle.
    out_ready = 1'b0;
    send(8'hAA, 8'h0F, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h0A);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    a = 8'h55; b = 8'hFF; op = 3'd1; mode = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    #1 chk("bp_accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    model_beat(8'h55, 8'hFF, 3'd1, 1'b0, 1'b0);
    #1 in_valid = 1'b0;
    drain();

    // XOR accumulate frame with mode/op disturbed mid-frame.
    send(8'h01, 8'h00, 3'd2, 1'b1, 1'b0);
    send(8'h02, 8'hFF, 3'd0, 1'b0, 1'b0);
    send(8'h04, 8'h00, 3'd5, 1'b0, 1'b1);
    // Saturating AND frame of five beats.
    for (int i = 0; i < 5; i++) send(8'hFF, 8'h00, 3'd0, 1'b1, 1'(i == 4));
    // Back-to-back PASS and NOT frames.
    send(8'h12, 8'h00, 3'd7, 1'b1, 1'b0);
    send(8'h34, 8'h00, 3'd7, 1'b1, 1'b1);
    send(8'h0F, 8'h00, 3'd6, 1'b1, 1'b0);
    send(8'hF0, 8'h00, 3'd6, 1'b1, 1'b1);
    drain();

    // Random elementwise beats with random backpressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
    end
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset while a result is held, then mid-frame.
    out_ready = 1'b0;
    send(8'h77, 8'h11, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_hold_valid", 32'(out_valid), 32'd0);
    sb.delete();
    m_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h11, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h22, 8'h00, 3'd1, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_count", 32'(out_count), 32'd0);
    m_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h55, 8'h00, 3'd3, 1'b1, 1'b1);
    drain();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
